// File: rtl/qea_host_sequencer.sv
// Host-side sequencer for QEA: loads gate context, seeds the state RAM with |0..0>, runs the core, streams the state out.
// Context writes land one cycle after each accepted beat; readout has 1-cycle RAM latency into a 2-deep skid FIFO that absorbs m_state_ready stalls.
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 s_ctx_valid,
    output logic                                 s_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
    output logic                                 m_state_valid,
    input  logic                                 m_state_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_state_data,
    output logic                                 m_state_last,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_error,
    output logic [31:0]                          o_exec_cycles
);

    localparam int WORD_W = PE_NUM*STATE_DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ONE_FX    = DATA_WIDTH'(64'd1 << NUM_FRAC_BIT);
    localparam logic [WORD_W-1:0]     INIT_WORD = {ONE_FX, {(WORD_W-DATA_WIDTH){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_INIT  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]                          r_state;
    logic [MAX_QBIT_WIDTH-1:0]           r_qbit;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ins;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ctx_cnt;
    logic                                r_ctx_en;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]  r_ctx_data;
    logic [STATE_ADDR_WIDTH-1:0]         r_last_addr;
    logic [STATE_ADDR_WIDTH-1:0]         r_addr;
    logic                                r_rd_all;
    logic                                r_rd_pend;
    logic                                r_rd_pend_last;
    logic [31:0]                         r_exec;
    logic                                r_run_first;
    logic                                r_error;
    logic [WORD_W-1:0]                   r_fifo_dat [0:1];
    logic [1:0]                          r_fifo_last;
    logic                                r_wr_ptr;
    logic                                r_rd_ptr;
    logic [1:0]                          r_fifo_cnt;

    logic [MAX_QBIT_WIDTH-1:0]           w_shift;
    logic [MAX_QBIT_WIDTH-1:0]           w_sh_amt;
    logic                                w_go_ok;
    logic [STATE_ADDR_WIDTH-1:0]         w_last_addr;
    logic                                w_ctx_hs;
    logic                                w_pop;
    logic [1:0]                          w_inflight;
    logic                                w_rd_issue;

    // N-1 as an all-ones mask; shift range is guaranteed by w_go_ok before it is latched
    assign w_shift     = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    assign w_sh_amt    = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH) - w_shift;
    assign w_go_ok     = (i_qbit_num > MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) &&
                         (w_shift <= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH));
    assign w_last_addr = {STATE_ADDR_WIDTH{1'b1}} >> w_sh_amt;

    assign s_ctx_ready = (r_state == S_LOAD) && (r_ctx_cnt < r_ins);
    assign w_ctx_hs    = s_ctx_valid && s_ctx_ready;

    assign m_state_valid = (r_fifo_cnt != 2'd0);
    assign m_state_data  = r_fifo_dat[r_rd_ptr];
    assign m_state_last  = r_fifo_last[r_rd_ptr];
    assign w_pop         = m_state_valid && m_state_ready;

    // Occupancy is taken net of this cycle's pop so a free-flowing sink sees one word per cycle
    assign w_inflight = r_fifo_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
    assign w_rd_issue = (r_state == S_READ) && !r_rd_all && (w_inflight < 2'd2);

    assign o_state_ena   = (r_state == S_INIT) || w_rd_issue;
    assign o_state_wea   = (r_state == S_INIT);
    assign o_state_addra = o_state_ena ? r_addr : '0;
    assign o_state_dina  = ((r_state == S_INIT) && (r_addr == '0)) ? INIT_WORD : '0;

    assign o_ctx_en      = r_ctx_en;
    assign o_ctx_wea     = r_ctx_en;
    assign o_ctx_addr    = r_ctx_addr;
    assign o_ctx_data    = r_ctx_data;
    assign o_qea_start   = (r_state == S_START);
    assign o_qbit_num    = r_qbit;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_error       = r_error;
    assign o_exec_cycles = r_exec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_qbit         <= '0;
            r_ins          <= '0;
            r_ctx_cnt      <= '0;
            r_ctx_en       <= 1'b0;
            r_ctx_addr     <= '0;
            r_ctx_data     <= '0;
            r_last_addr    <= '0;
            r_addr         <= '0;
            r_rd_all       <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
            r_exec         <= '0;
            r_run_first    <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_error        <= 1'b0;
            r_ctx_en       <= 1'b0;
            r_rd_pend      <= w_rd_issue;
            r_rd_pend_last <= w_rd_issue && (r_addr == r_last_addr);
            if (w_ctx_hs) begin
                r_ctx_en   <= 1'b1;
                r_ctx_addr <= r_ctx_cnt;
                r_ctx_data <= s_ctx_data;
                r_ctx_cnt  <= r_ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        if (w_go_ok) begin
                            r_qbit      <= i_qbit_num;
                            r_ins       <= i_ins_num;
                            r_last_addr <= w_last_addr;
                            r_ctx_cnt   <= '0;
                            r_addr      <= '0;
                            r_state     <= (i_ins_num == '0) ? S_INIT : S_LOAD;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_ctx_en && (r_ctx_cnt == r_ins))
                        r_state <= S_INIT;
                end
                S_INIT: begin
                    if (r_addr == r_last_addr) begin
                        r_addr  <= '0;
                        r_state <= S_START;
                    end else begin
                        r_addr <= r_addr + STATE_ADDR_WIDTH'(1);
                    end
                end
                S_START: begin
                    r_exec      <= '0;
                    r_run_first <= 1'b1;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (r_exec != '1)
                        r_exec <= r_exec + 32'd1;
                    r_run_first <= 1'b0;
                    // a stale complete from the previous run is masked for one cycle
                    if (!r_run_first && i_qea_complete) begin
                        r_addr   <= '0;
                        r_rd_all <= 1'b0;
                        r_state  <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_rd_issue) begin
                        if (r_addr == r_last_addr)
                            r_rd_all <= 1'b1;
                        else
                            r_addr <= r_addr + STATE_ADDR_WIDTH'(1);
                    end
                    if (w_pop && m_state_last)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_dat[0] <= '0;
            r_fifo_dat[1] <= '0;
            r_fifo_last   <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_fifo_cnt    <= '0;
        end else begin
            if (r_rd_pend) begin
                r_fifo_dat[r_wr_ptr]  <= i_qea_state_dout;
                r_fifo_last[r_wr_ptr] <= r_rd_pend_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Randomized bench for qea_host_sequencer with a state-RAM / QEA behavioural model and queue-based scoreboard.
module tb_qea_host_sequencer;

    localparam logic [255:0] INIT_EXP = {64'h40000000_00000000, 192'd0};

    logic         clk;
    logic         rst;
    logic         i_go;
    logic [5:0]   i_qbit_num;
    logic [15:0]  i_ins_num;
    logic         s_ctx_valid;
    logic         s_ctx_ready;
    logic [63:0]  s_ctx_data;
    logic         o_qea_start;
    logic [5:0]   o_qbit_num;
    logic         o_ctx_en;
    logic         o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic         o_state_ena;
    logic         o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic         i_qea_complete;
    logic [255:0] i_qea_state_dout;
    logic         m_state_valid;
    logic         m_state_ready;
    logic [255:0] m_state_data;
    logic         m_state_last;
    logic         o_busy;
    logic         o_done;
    logic         o_error;
    logic [31:0]  o_exec_cycles;

    qea_host_sequencer dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
        .o_qea_start(o_qea_start), .o_qbit_num(o_qbit_num),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout),
        .m_state_valid(m_state_valid), .m_state_ready(m_state_ready), .m_state_data(m_state_data),
        .m_state_last(m_state_last), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_exec_cycles(o_exec_cycles)
    );

    int n_chk, n_pass;

    logic [63:0]  ctx_words [$];
    int           ctx_idx, ctx_n;
    bit           ctx_bp, rd_bp;
    logic [255:0] mem [0:255];
    logic [255:0] exp_mem [0:255];
    int           cur_n, cur_q, cpl_delay, qea_cnt;

    int           ctx_a_q [$];
    logic [63:0]  ctx_d_q [$];
    int           init_a_q [$];
    logic [255:0] init_d_q [$];
    logic [255:0] out_d_q [$];
    bit           out_l_q [$];
    int           starts, dones, errs, busy_seen, stall_bad, wea_bad;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [255:0] out_flags();
        return {239'd0, o_busy, o_qea_start, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea,
                s_ctx_ready, m_state_valid, m_state_last, o_done, o_error, |o_qbit_num,
                |o_ctx_addr, |o_ctx_data, |o_state_addra, |o_state_dina, |m_state_data};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source of context beats: a beat seen valid&ready at the negedge is consumed by the next posedge
    initial begin
        bit acc;
        s_ctx_valid = 1'b0;
        s_ctx_data  = '0;
        forever begin
            @(negedge clk);
            acc = s_ctx_valid && s_ctx_ready;
            @(posedge clk);
            #1;
            if (acc) ctx_idx++;
            if (ctx_idx < ctx_n) begin
                s_ctx_valid = !ctx_bp || ($urandom_range(0, 1) == 1);
                s_ctx_data  = ctx_words[ctx_idx];
            end else begin
                s_ctx_valid = 1'b0;
                s_ctx_data  = '0;
            end
        end
    end

    initial begin
        m_state_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_state_ready = rd_bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    // State RAM: write-first port A, registered read data
    initial begin
        bit           en, we;
        logic [15:0]  a;
        logic [255:0] d;
        i_qea_state_dout = '0;
        forever begin
            @(negedge clk);
            en = o_state_ena; we = o_state_wea; a = o_state_addra; d = o_state_dina;
            @(posedge clk);
            #1;
            if (en) begin
                if (we) mem[a[7:0]] = d;
                else    i_qea_state_dout = mem[a[7:0]];
            end
        end
    end

    // QEA core: after a start, raises complete in the cycle cpl_delay cycles later and leaves a new state vector behind
    initial begin
        i_qea_complete = 1'b0;
        qea_cnt = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                i_qea_complete = 1'b0;
                qea_cnt = -1;
            end else if (o_qea_start) begin
                i_qea_complete = 1'b0;
                qea_cnt = 0;
            end else if (qea_cnt >= 0) begin
                qea_cnt++;
                if (qea_cnt == cpl_delay) begin
                    for (int i = 0; i < cur_n; i++) begin
                        exp_mem[i] = rand256();
                        mem[i]     = exp_mem[i];
                    end
                    i_qea_complete = 1'b1;
                    qea_cnt = -1;
                end
            end
        end
    end

    initial begin
        bit           stall_prev;
        logic [255:0] hold_d;
        bit           hold_l;
        stall_prev = 0;
        hold_d = '0;
        hold_l = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (o_ctx_en) begin
                    ctx_a_q.push_back(int'(o_ctx_addr));
                    ctx_d_q.push_back(o_ctx_data);
                    if (!o_ctx_wea) wea_bad++;
                end
                if (o_state_ena && o_state_wea) begin
                    init_a_q.push_back(int'(o_state_addra));
                    init_d_q.push_back(o_state_dina);
                end
                if (o_qea_start) starts++;
                if (o_done) dones++;
                if (o_error) errs++;
                if (o_busy) busy_seen++;
                if (stall_prev && !(m_state_valid && m_state_data == hold_d && m_state_last == hold_l))
                    stall_bad++;
                if (m_state_valid && m_state_ready) begin
                    out_d_q.push_back(m_state_data);
                    out_l_q.push_back(m_state_last);
                end
                stall_prev = m_state_valid && !m_state_ready;
                hold_d = m_state_data;
                hold_l = m_state_last;
            end
        end
    end

    task automatic clear_obs();
        ctx_a_q.delete(); ctx_d_q.delete(); init_a_q.delete(); init_d_q.delete();
        out_d_q.delete(); out_l_q.delete();
        starts = 0; dones = 0; errs = 0; busy_seen = 0; stall_bad = 0; wea_bad = 0;
    endtask

    task automatic start_run(input int q, input int ins, input bit cbp, input bit rbp, input int d);
        cur_q = q;
        cur_n = 1 << (q - 2);
        cpl_delay = d;
        ctx_words.delete();
        for (int i = 0; i < ins; i++) ctx_words.push_back({$urandom, $urandom});
        ctx_n = ins;
        ctx_idx = 0;
        ctx_bp = cbp;
        rd_bp = rbp;
        clear_obs();
        i_go = 1'b1;
        i_qbit_num = 6'(q);
        i_ins_num = 16'(ins);
        tick();
        i_go = 1'b0;
    endtask

    task automatic finish_run(input bit mid_go);
        int ctx_bad, init_bad, out_bad, lasts;
        for (int c = 0; c < 20000 && dones == 0; c++) begin
            if (mid_go && c == 60) begin
                i_go = 1'b1;
                i_qbit_num = 6'd5;
            end else begin
                i_go = 1'b0;
            end
            tick();
        end
        i_go = 1'b0;
        tick();
        tick();
        chk("done_pulses", dones, 1);
        chk("ctx_count", ctx_a_q.size(), ctx_n);
        ctx_bad = 0;
        for (int i = 0; i < ctx_a_q.size() && i < ctx_n; i++)
            if (ctx_a_q[i] != i || ctx_d_q[i] !== ctx_words[i]) ctx_bad++;
        chk("ctx_addr_data", ctx_bad, 0);
        chk("ctx_wea", wea_bad, 0);
        chk("init_count", init_a_q.size(), cur_n);
        init_bad = 0;
        for (int i = 0; i < init_a_q.size(); i++)
            if (init_a_q[i] != i || init_d_q[i] !== ((i == 0) ? INIT_EXP : 256'd0)) init_bad++;
        chk("init_addr_data", init_bad, 0);
        if (init_d_q.size() > 0) chk("init_word0", init_d_q[0], INIT_EXP);
        chk("start_pulses", starts, 1);
        chk("read_count", out_d_q.size(), cur_n);
        out_bad = 0;
        lasts = 0;
        for (int i = 0; i < out_d_q.size(); i++) begin
            if (i >= cur_n || out_d_q[i] !== exp_mem[i] || out_l_q[i] != (i == cur_n - 1)) out_bad++;
            if (out_l_q[i]) lasts++;
        end
        chk("read_order_data_last", out_bad, 0);
        chk("last_count", lasts, 1);
        chk("exec_cycles", o_exec_cycles, cpl_delay);
        chk("qbit_out", o_qbit_num, cur_q);
        chk("stall_stable", stall_bad, 0);
        chk("no_error", errs, 0);
        chk("idle_after", o_busy, 0);
    endtask

    task automatic run_case(input int q, input int ins, input bit cbp, input bit rbp, input int d, input bit mid_go);
        start_run(q, ins, cbp, rbp, d);
        finish_run(mid_go);
    endtask

    task automatic try_invalid(input int q);
        clear_obs();
        i_go = 1'b1;
        i_qbit_num = 6'(q);
        i_ins_num = 16'd5;
        tick();
        i_go = 1'b0;
        repeat (4) tick();
        chk("inv_error_pulse", errs, 1);
        chk("inv_busy", busy_seen, 0);
        chk("inv_start", starts, 0);
        chk("inv_writes", ctx_a_q.size() + init_a_q.size(), 0);
        chk("inv_qbit_hold", o_qbit_num, cur_q);
    endtask

    task automatic reset_pulse_check(input string tag);
        #1;
        rst = 1'b1;
        #1;
        chk({tag, "_flags"}, out_flags(), 256'd0);
        chk({tag, "_exec"}, o_exec_cycles, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0;
        ctx_n = 0; ctx_idx = 0; ctx_bp = 0; rd_bp = 0; cur_n = 0; cur_q = 0; cpl_delay = 2;
        clear_obs();
        repeat (3) tick();
        chk("reset_flags", out_flags(), 256'd0);
        chk("reset_exec", o_exec_cycles, 0);
        rst = 1'b0;
        tick();

        run_case(10, 341, 0, 0, 500, 1);
        run_case(6, 40, 1, 0, $urandom_range(2, 60), 0);
        run_case(10, 12, 0, 1, 37, 0);
        run_case(3, 0, 1, 1, 2, 0);

        try_invalid(2);
        try_invalid(19);

        start_run(6, 20, 0, 0, 300);
        for (int c = 0; c < 2000 && starts == 0; c++) tick();
        repeat (10) tick();
        chk("run_reached_busy", o_busy, 1);
        reset_pulse_check("rst_in_run");

        start_run(7, 5, 0, 1, 20);
        for (int c = 0; c < 3000 && out_d_q.size() < 3; c++) tick();
        chk("read_reached", out_d_q.size() >= 3, 1);
        reset_pulse_check("rst_in_read");

        run_case(8, 25, 1, 1, 45, 0);

        for (int r = 0; r < 3; r++)
            run_case($urandom_range(3, 8), $urandom_range(0, 30), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(2, 50), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qea_host_sequencer.md
Name: qea_host_sequencer

Overview:
- Hardware initiator for the QEA core's load/run/readout interface; replaces the bench-driven sequence in synthesised systems.
- Accepts a gate-context stream and initialises the state RAM to |0...0>. It then pulses start and waits for complete.
- It reads the final state vector back out as a valid/ready stream and reports execution cycles.
- Sits between a host DMA/AXI-stream bridge and QEA.

Parameters:
PE_NUM_WIDTH, 2, log2 of PE count
PE_NUM, 4, PEs (lanes per state word)
DATA_WIDTH, 32, real/imag component width
MAX_QBIT_WIDTH, 6, width of qubit-count field
STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude {real,imag}
STATE_ADDR_WIDTH, 16, state RAM address width
GATE_CONTEXT_DATA_WIDTH, 2*DATA_WIDTH, context word width
GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
NUM_FRAC_BIT, 30, fixed-point fraction bits (1.0 = 1<<NUM_FRAC_BIT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_go  in  1  start a full run; sampled only in IDLE
i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on accepted i_go
i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context words to load, latched on accepted i_go
s_ctx_valid  in  1  context beat valid
s_ctx_ready  out  1  context beat accepted when valid&ready
s_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
o_qea_start  out  1  one-cycle start pulse to QEA
o_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count to QEA
o_ctx_en, o_ctx_wea  out  1 each  context RAM enable/write
o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context RAM address
o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  context RAM data
o_state_ena, o_state_wea  out  1 each  state RAM port-A enable/write
o_state_addra  out  STATE_ADDR_WIDTH  state RAM address
o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state RAM write data
i_qea_complete  in  1  QEA done level
i_qea_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read data, 1-cycle latency
m_state_valid  out  1  readout word valid
m_state_ready  in  1  readout sink ready
m_state_data  out  PE_NUM*STATE_DATA_WIDTH  readout word
m_state_last  out  1  marks word N-1
o_busy  out  1  high whenever state != IDLE
o_done  out  1  one-cycle pulse after last readout accepted
o_error  out  1  one-cycle pulse on rejected i_go
o_exec_cycles  out  32  cycles from start pulse to complete seen

Behaviour:
- Reset (async, any time incl. mid-run): FSM -> IDLE. All outputs 0, including o_exec_cycles. FIFO and counters cleared. QEA strobes deasserted immediately.
- N = 2^(qbit_num - PE_NUM_WIDTH) state words.
- i_go is rejected (o_error pulses, stay IDLE) when qbit_num <= PE_NUM_WIDTH or qbit_num - PE_NUM_WIDTH > STATE_ADDR_WIDTH. i_go is ignored while busy.
- FSM states: IDLE -> LOAD_CTX -> INIT_STATE -> START -> RUN -> READ -> DONE -> IDLE.
- LOAD_CTX:
  - s_ctx_ready=1 while accepted count < ins_num.
  - A handshake in cycle n gives o_ctx_en=o_ctx_wea=1 in cycle n+1, with o_ctx_addr = beat index (0,1,...) and o_ctx_data = beat.
  - Exit after the last write cycle. ins_num=0 goes straight to INIT_STATE.
- INIT_STATE:
  - N consecutive cycles with o_state_ena=o_state_wea=1, addra 0..N-1.
  - Word at addr 0: MS lane = {DATA_WIDTH'(1<<NUM_FRAC_BIT), DATA_WIDTH'0}, i.e. 64'h40000000_00000000 at defaults; all other lanes 0. All other words are 0.
- START:
  - o_qea_start=1 for exactly one cycle; o_exec_cycles cleared to 0.
- RUN:
  - o_exec_cycles increments every cycle starting the cycle after the start pulse.
  - i_qea_complete is ignored in the first RUN cycle. From the second cycle, complete=1 freezes the counter and moves to READ. The counter saturates at 2^32-1.
- READ:
  - Read issue: o_state_ena=1, o_state_wea=0, addra 0..N-1 ascending.
  - Data captured 1 cycle after issue into a 2-entry FIFO. A read issues only if (outstanding + occupancy) < 2, so no word is lost under backpressure.
  - m_state_valid = FIFO non-empty; data/last stable while valid&!ready.
  - m_state_last=1 only with word N-1.
  - With m_state_ready held high, throughput is 1 word/cycle.
- DONE: o_done=1 one cycle -> IDLE; o_exec_cycles holds its value until the next START.
- o_qbit_num holds the latched value from accepted i_go until the next accepted i_go.

Test Plan:
- Full run: qbit_num=10, ins_num=341 random words, ready=1, complete asserted 500 cycles after start -> 341 ctx writes at addr 0..340 with matching data; 256 init writes, addr0 MS lane 64'h40000000_00000000; one start pulse; 256 readout words, last on #255; o_exec_cycles=500; one o_done.
- Context backpressure: s_ctx_valid toggled randomly -> writes only on handshakes; addresses contiguous with no gaps or duplicates.
- Readout backpressure: m_state_ready random 30% -> all 256 words delivered in address order with none dropped; data stable while stalled.
- Invalid: qbit_num=2 and qbit_num=19 -> o_error one cycle, no QEA strobes, o_busy stays 0; i_go pulsed mid-run -> ignored.
- Edge: ins_num=0, qbit_num=3 (N=2) -> no ctx writes, 2 init writes, 2 readout words with last on the second.
- Reset in RUN and mid-READ -> all outputs 0 the same cycle; a fresh i_go then completes a normal run.
